dbg_mem_master: RTL

- Debug-side initiator for the core's second-port debug interfaces: the instruction RAM port (A2/WD2/WE2/RD2) and the data RAM port.
- Accepts burst read/write commands from a host link over valid/ready handshakes and drives the matching RAM port.
- Returns read data with backpressure.
- Asserts a hold output while a transfer is in flight so the top level can keep the core in reset during program load or data dump.

---
 rtl/dbg_pkg.sv | 36 +++
 rtl/dbg_mem_master_if.sv | 56 +++++
 rtl/dbg_port_mux.sv | 71 +++++++
 rtl/dbg_mem_master.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// -----------------------------------------------------------------------------
// dbg_pkg
// Shared definitions for the debug memory master: FSM state encoding, RAM
// port selector values, word size, and small helpers for address stepping and
// byte-enable masking.
// No ports (package).
// -----------------------------------------------------------------------------
package dbg_pkg;

  localparam logic        SEL_INST   = 1'b0;
  localparam logic        SEL_DATA   = 1'b1;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RESP     = 3'd4
`ifdef DBG_WRITE_VERIFY_EN
    ,
    ST_VERIFY   = 3'd5
`endif
  } dbg_state_e;

  // Word step; wraps modulo 2^32 by construction.
  function automatic logic [31:0] next_addr(input logic [31:0] addr);
    return addr + 32'(WORD_BYTES);
  endfunction

  // Expands 4 byte enables into a 32-bit bit mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/dbg_mem_master_if.sv
// -----------------------------------------------------------------------------
// dbg_mem_master_if
// Host link of the debug memory master: command, write-beat and read-data
// channels plus status flags.
//   slave  modport : used by dbg_mem_master
//   master modport : used by the host side
//
// Handshake rule for all three channels (cmd, wdata, rdata): a transfer
// happens on a rising clock edge where both valid and ready are 1. The
// sender keeps valid and its payload stable until that edge; ready may
// change freely and does not depend combinationally on valid.
// -----------------------------------------------------------------------------
interface dbg_mem_master_if #(
  parameter int LEN_W = 8
);
  // command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic             cmd_sel;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  // write-beat channel
  logic             wdata_valid;
  logic             wdata_ready;
  logic [31:0]      wdata;
  logic [3:0]       wbe;
  // read-data channel
  logic             rdata_valid;
  logic             rdata_ready;
  logic [31:0]      rdata;
  logic             rdata_last;
  // status
  logic             err;
  logic             busy;
  logic             core_hold;

  modport slave (
    input  cmd_valid, cmd_write, cmd_sel, cmd_addr, cmd_len,
    input  wdata_valid, wdata, wbe,
    input  rdata_ready,
    output cmd_ready, wdata_ready,
    output rdata_valid, rdata, rdata_last,
    output err, busy, core_hold
  );

  modport master (
    output cmd_valid, cmd_write, cmd_sel, cmd_addr, cmd_len,
    output wdata_valid, wdata, wbe,
    output rdata_ready,
    input  cmd_ready, wdata_ready,
    input  rdata_valid, rdata, rdata_last,
    input  err, busy, core_hold
  );

endinterface

// File: rtl/dbg_port_mux.sv
// -----------------------------------------------------------------------------
// dbg_port_mux
// Steers one access onto either the instruction-RAM or data-RAM port 2.
// The unselected port always sees WE2=0; each port's A2/WD2 hold their last
// driven values when that port is not being driven.
// Ports:
//   clk_i, rst_ni         clock, async active-low reset
//   sel_i                 SEL_INST / SEL_DATA
//   a_en_i                drive A2 from addr_i this cycle
//   w_en_i                drive WD2 from wd_i and WE2 from we_i this cycle
//   addr_i, wd_i, we_i    access payload
//   rd_o                  RD2 of the selected RAM
//   inst_* / data_*       the two RAM port-2 interfaces
// -----------------------------------------------------------------------------
module dbg_port_mux
  import dbg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sel_i,
  input  logic        a_en_i,
  input  logic        w_en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wd_i,
  input  logic [3:0]  we_i,
  output logic [31:0] rd_o,
  output logic [31:0] inst_a2_o,
  output logic [31:0] inst_wd2_o,
  output logic [3:0]  inst_we2_o,
  input  logic [31:0] inst_rd2_i,
  output logic [31:0] data_a2_o,
  output logic [31:0] data_wd2_o,
  output logic [3:0]  data_we2_o,
  input  logic [31:0] data_rd2_i
);

  logic [31:0] inst_a2_q, inst_wd2_q, data_a2_q, data_wd2_q;
  logic        inst_a_en, inst_w_en, data_a_en, data_w_en;

  always_comb begin
    inst_a_en  = a_en_i && (sel_i == SEL_INST);
    inst_w_en  = w_en_i && (sel_i == SEL_INST);
    data_a_en  = a_en_i && (sel_i == SEL_DATA);
    data_w_en  = w_en_i && (sel_i == SEL_DATA);

    inst_a2_o  = inst_a_en ? addr_i : inst_a2_q;
    inst_wd2_o = inst_w_en ? wd_i   : inst_wd2_q;
    inst_we2_o = inst_w_en ? we_i   : 4'h0;
    data_a2_o  = data_a_en ? addr_i : data_a2_q;
    data_wd2_o = data_w_en ? wd_i   : data_wd2_q;
    data_we2_o = data_w_en ? we_i   : 4'h0;

    rd_o       = (sel_i == SEL_DATA) ? data_rd2_i : inst_rd2_i;
  end

  // Remember what each port last showed so idle ports stay quiet.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inst_a2_q  <= '0;
      inst_wd2_q <= '0;
      data_a2_q  <= '0;
      data_wd2_q <= '0;
    end else begin
      inst_a2_q  <= inst_a2_o;
      inst_wd2_q <= inst_wd2_o;
      data_a2_q  <= data_a2_o;
      data_wd2_q <= data_wd2_o;
    end
  end

endmodule

// File: rtl/dbg_mem_master.sv
// -----------------------------------------------------------------------------
// dbg_mem_master
// Debug-side initiator for the instruction/data RAM second ports. Takes burst
// read/write commands from the host link and walks the selected RAM one word
// at a time; read words are returned with backpressure. core_hold follows
// busy so the top level can keep the core in reset while a transfer runs.
//
// Optional feature macro: DBG_WRITE_VERIFY_EN
//   When defined, every write beat is read back (VERIFY state) and the enabled
//   bytes compared; a mismatch sets the sticky verify_err output, which clears
//   on the next command accept.
//
// Parameters: LEN_W (burst length field width), RD_LAT (RAM read latency, 1..2)
// Ports:
//   CPU_CLK, CPU_RST      clock, async active-low reset
//   host                  host link (dbg_mem_master_if.slave)
//   Dbg_InstRAM_*         instruction RAM port 2 (A2/WD2/WE2 out, RD2 in)
//   Dbg_DataRAM_*         data RAM port 2
//   verify_err            (DBG_WRITE_VERIFY_EN only) sticky verify mismatch
//   dbg_state_o           current FSM state, for observation
// -----------------------------------------------------------------------------
module dbg_mem_master
  import dbg_pkg::*;
#(
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic               CPU_CLK,
  input  logic               CPU_RST,
  dbg_mem_master_if.slave    host,
  output logic [31:0]        Dbg_InstRAM_A2,
  output logic [31:0]        Dbg_InstRAM_WD2,
  output logic [3:0]         Dbg_InstRAM_WE2,
  input  logic [31:0]        Dbg_InstRAM_RD2,
  output logic [31:0]        Dbg_DataRAM_A2,
  output logic [31:0]        Dbg_DataRAM_WD2,
  output logic [3:0]         Dbg_DataRAM_WE2,
  input  logic [31:0]        Dbg_DataRAM_RD2,
`ifdef DBG_WRITE_VERIFY_EN
  output logic               verify_err,
`endif
  output dbg_state_e         dbg_state_o
);

  dbg_state_e       state_q, state_d;
  logic             sel_q, sel_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       wait_q, wait_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             rlast_q, rlast_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
`ifdef DBG_WRITE_VERIFY_EN
  logic [31:0]      vdata_q, vdata_d;
  logic [3:0]       vbe_q, vbe_d;
  logic             verr_q, verr_d;
`endif

  logic             port_a_en, port_w_en, wready;
  logic [31:0]      port_rd;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    rdata_d   = rdata_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    err_d     = 1'b0;
    port_a_en = 1'b0;
    port_w_en = 1'b0;
    wready    = 1'b0;
`ifdef DBG_WRITE_VERIFY_EN
    vdata_d   = vdata_q;
    vbe_d     = vbe_q;
    verr_d    = verr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (host.cmd_valid && ready_q) begin
          sel_d  = host.cmd_sel;
          addr_d = host.cmd_addr;
          cnt_d  = host.cmd_len;
`ifdef DBG_WRITE_VERIFY_EN
          verr_d = 1'b0;
`endif
          if (host.cmd_addr[1:0] != 2'b00) err_d = 1'b1;
          else if (host.cmd_write)          state_d = ST_WRITE;
          else                              state_d = ST_RD_ISSUE;
        end
      end

      ST_WRITE: begin
        wready = 1'b1;
        if (host.wdata_valid) begin
          // The RAM port carries this beat in the handshake cycle itself.
          port_a_en = 1'b1;
          port_w_en = 1'b1;
`ifdef DBG_WRITE_VERIFY_EN
          vdata_d = host.wdata;
          vbe_d   = host.wbe;
          wait_d  = 2'd0;
          state_d = ST_VERIFY;
`else
          addr_d = next_addr(addr_q);
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == '0) state_d = ST_IDLE;
`endif
        end
      end

      ST_RD_ISSUE: begin
        port_a_en = 1'b1;
        wait_d    = 2'd0;
        state_d   = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        port_a_en = 1'b1;
        if (wait_q == 2'(RD_LAT - 1)) begin
          rdata_d  = port_rd;
          rvalid_d = 1'b1;
          rlast_d  = (cnt_q == '0);
          state_d  = ST_RESP;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      ST_RESP: begin
        if (host.rdata_ready) begin
          rvalid_d = 1'b0;
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            addr_d  = next_addr(addr_q);
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = ST_RD_ISSUE;
          end
        end
      end

`ifdef DBG_WRITE_VERIFY_EN
      // wait_q==0 is the read-issue cycle, so data arrives when wait_q==RD_LAT.
      ST_VERIFY: begin
        port_a_en = 1'b1;
        if (wait_q == 2'(RD_LAT)) begin
          if (((port_rd ^ vdata_q) & be_mask(vbe_q)) != 32'h0) verr_d = 1'b1;
          addr_d  = next_addr(addr_q);
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == '0) ? ST_IDLE : ST_WRITE;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
    if (!CPU_RST) begin
      state_q  <= ST_IDLE;
      sel_q    <= SEL_INST;
      addr_q   <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
`ifdef DBG_WRITE_VERIFY_EN
      vdata_q  <= '0;
      vbe_q    <= '0;
      verr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
`ifdef DBG_WRITE_VERIFY_EN
      vdata_q  <= vdata_d;
      vbe_q    <= vbe_d;
      verr_q   <= verr_d;
`endif
    end
  end

  dbg_port_mux u_port_mux (
    .clk_i      (CPU_CLK),
    .rst_ni     (CPU_RST),
    .sel_i      (sel_q),
    .a_en_i     (port_a_en),
    .w_en_i     (port_w_en),
    .addr_i     (addr_q),
    .wd_i       (host.wdata),
    .we_i       (host.wbe),
    .rd_o       (port_rd),
    .inst_a2_o  (Dbg_InstRAM_A2),
    .inst_wd2_o (Dbg_InstRAM_WD2),
    .inst_we2_o (Dbg_InstRAM_WE2),
    .inst_rd2_i (Dbg_InstRAM_RD2),
    .data_a2_o  (Dbg_DataRAM_A2),
    .data_wd2_o (Dbg_DataRAM_WD2),
    .data_we2_o (Dbg_DataRAM_WE2),
    .data_rd2_i (Dbg_DataRAM_RD2)
  );

  // ready_q is registered so cmd_ready reads 0 while reset is held.
  assign host.cmd_ready   = ready_q;
  assign host.wdata_ready = wready;
  assign host.rdata_valid = rvalid_q;
  assign host.rdata       = rdata_q;
  assign host.rdata_last  = rlast_q;
  assign host.err         = err_q;
  assign host.busy        = busy_q;
  assign host.core_hold   = busy_q;
`ifdef DBG_WRITE_VERIFY_EN
  assign verify_err       = verr_q;
`endif
  assign dbg_state_o      = state_q;

endmodule
